// File: rtl/sdram_stream_writer_if.sv
// rtl/sdram_stream_writer_if.sv - sample stream and SDRAM write-master port bundle
interface sdram_stream_writer_if;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        wr_fixed_location;
  logic [31:0] wr_write_base;
  logic [31:0] wr_write_length;
  logic        wr_go;
  logic        wr_done;
  logic        wr_write_buffer;
  logic [15:0] wr_buffer_input_data;
  logic        wr_buffer_full;

  modport master (
    input  s_data, s_valid, wr_done, wr_buffer_full,
    output s_ready, wr_fixed_location, wr_write_base, wr_write_length,
           wr_go, wr_write_buffer, wr_buffer_input_data
  );

  modport slave (
    output s_data, s_valid, wr_done, wr_buffer_full,
    input  s_ready, wr_fixed_location, wr_write_base, wr_write_length,
           wr_go, wr_write_buffer, wr_buffer_input_data
  );
endinterface

// File: rtl/sdram_stream_writer.sv
// rtl/sdram_stream_writer.sv - cuts a 16-bit sample stream into fixed bursts written around an SDRAM ring
module sdram_stream_writer #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter logic [31:0] REGION_BYTES = 32'h0200_0000,
  parameter int unsigned BURST_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  sdram_stream_writer_if.master bus,
  output logic                  busy,
  output logic [15:0]           wrap_count
);

  localparam logic [31:0] BURST_BYTES = 32'(2 * BURST_WORDS);
  localparam logic [16:0] BURST_CNT   = 17'(BURST_WORDS);
  localparam logic [32:0] RING_END    = {1'b0, BASE_ADDR} + {1'b0, REGION_BYTES};

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    FILL      = 3'd2,
    WAIT_DONE = 3'd3,
    ADVANCE   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] base_q;
  logic [16:0] count_q;
  logic [15:0] wrap_q;
  logic        ready;
  logic        push;
  logic [32:0] next_base;

  assign ready     = (state_q == FILL) && !bus.wr_buffer_full && (count_q < BURST_CNT);
  assign push      = bus.s_valid && ready;
  assign next_base = {1'b0, base_q} + {1'b0, BURST_BYTES};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Base stays frozen from ARM through WAIT_DONE; only ADVANCE moves it.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q  <= BASE_ADDR;
      count_q <= '0;
      wrap_q  <= '0;
    end else begin
      if (push) begin
        count_q <= count_q + 17'd1;
      end
      if (state_q == ADVANCE) begin
        count_q <= '0;
        if (next_base >= RING_END) begin
          base_q <= BASE_ADDR;
          if (wrap_q != 16'hFFFF) begin
            wrap_q <= wrap_q + 16'd1;
          end
        end else begin
          base_q <= next_base[31:0];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (enable) state_d = ARM;
      ARM:       state_d = FILL;
      FILL:      if (push && (count_q == BURST_CNT - 17'd1)) state_d = WAIT_DONE;
      WAIT_DONE: if (bus.wr_done) state_d = ADVANCE;
      ADVANCE:   state_d = enable ? ARM : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.wr_go           = 1'b0;
    bus.s_ready         = 1'b0;
    bus.wr_write_buffer = 1'b0;
    busy                = 1'b1;
    case (state_q)
      IDLE: busy = 1'b0;
      ARM:  bus.wr_go = 1'b1;
      FILL: begin
        bus.s_ready         = ready;
        bus.wr_write_buffer = push;
      end
      default: ;
    endcase
  end

  assign bus.wr_fixed_location    = 1'b0;
  assign bus.wr_write_base        = base_q;
  assign bus.wr_write_length      = BURST_BYTES;
  assign bus.wr_buffer_input_data = bus.s_data;
  assign wrap_count               = wrap_q;

endmodule

// File: tb/tb_sdram_stream_writer.sv
// tb/tb_sdram_stream_writer.sv - directed self-checking bench for sdram_stream_writer (4-word bursts, 16-byte ring)
module tb_sdram_stream_writer;
  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        busy;
  logic [15:0] wrap_count;

  sdram_stream_writer_if bus();

  sdram_stream_writer #(
    .BASE_ADDR   (32'h0000_0000),
    .REGION_BYTES(32'd16),
    .BURST_WORDS (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .bus       (bus),
    .busy      (busy),
    .wrap_count(wrap_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  logic [31:0] go_bases[$];
  logic [15:0] push_data[$];
  int          burst_pushes[$];
  int          pushes_since_go;
  bit          seen_go;
  bit          pushed;

  // Observe at negedge, then advance the source one step after the rising edge.
  task automatic step();
    @(negedge clk);
    if (bus.wr_go) begin
      if (seen_go) burst_pushes.push_back(pushes_since_go);
      pushes_since_go = 0;
      seen_go = 1'b1;
      go_bases.push_back(bus.wr_write_base);
    end
    if (bus.wr_write_buffer) begin
      push_data.push_back(bus.wr_buffer_input_data);
      pushes_since_go++;
    end
    pushed = bus.wr_write_buffer;
    @(posedge clk);
    #1;
    if (pushed) bus.s_data = bus.s_data + 16'd1;
  endtask

  task automatic clear_log();
    go_bases.delete();
    push_data.delete();
    burst_pushes.delete();
    pushes_since_go = 0;
    seen_go = 1'b0;
    bus.s_data = 16'd0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    enable = 1'b0;
    bus.s_valid = 1'b0;
    bus.wr_buffer_full = 1'b0;
    bus.wr_done = 1'b1;
    step();
    step();
    reset = 1'b0;
    clear_log();
  endtask

  task automatic wait_go(input int n);
    for (int i = 0; i < 300 && go_bases.size() < n; i++) step();
    if (go_bases.size() < n) begin
      checks++;
      $display("FAIL wait_go: saw %0d go pulses, required %0d", go_bases.size(), n);
    end
  endtask

  task automatic wait_push(input int n);
    for (int i = 0; i < 300 && push_data.size() < n; i++) step();
    if (push_data.size() < n) begin
      checks++;
      $display("FAIL wait_push: saw %0d pushes, required %0d", push_data.size(), n);
    end
  endtask

  task automatic start_stream();
    enable = 1'b1;
    bus.s_valid = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data = 16'h1234;
    bus.wr_buffer_full = 1'b0;
    bus.wr_done = 1'b1;
    step();
    step();
    checks++;
    if ({busy, bus.wr_go, bus.s_ready, bus.wr_write_buffer, bus.wr_fixed_location} !== 5'b0) begin
      $display("FAIL reset_ctrl: busy/go/ready/wb/fixed=%b required 00000",
               {busy, bus.wr_go, bus.s_ready, bus.wr_write_buffer, bus.wr_fixed_location});
    end else passed++;
    checks++;
    if (bus.wr_write_base !== 32'd0) $display("FAIL reset_base: got %h required 0", bus.wr_write_base);
    else passed++;
    checks++;
    if (wrap_count !== 16'd0) $display("FAIL reset_wrap: got %h required 0", wrap_count);
    else passed++;
    checks++;
    if (bus.wr_write_length !== 32'd8) $display("FAIL write_length: got %0d required 8", bus.wr_write_length);
    else passed++;
    reset = 1'b0;
    enable = 1'b0;
    bus.s_valid = 1'b0;
    step();
  endtask

  task automatic test_ring_fill();
    logic [31:0] exp_base[4];
    bit ok;
    exp_base = '{32'd0, 32'd8, 32'd0, 32'd8};
    apply_reset();
    start_stream();
    wait_go(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (go_bases[i] !== exp_base[i]) $display("FAIL ring_base%0d: got %h required %h", i, go_bases[i], exp_base[i]);
      else passed++;
    end
    checks++;
    if (wrap_count !== 16'd1) $display("FAIL ring_wrap: got %0d required 1", wrap_count);
    else passed++;
    ok = (push_data.size() == 12);
    for (int i = 0; i < 12; i++) if (push_data[i] !== 16'(i)) ok = 1'b0;
    checks++;
    if (!ok) $display("FAIL ring_data_order: %0d pushes, first %h, required 12 pushes 0..11", push_data.size(), push_data[0]);
    else passed++;
    checks++;
    if (burst_pushes.size() != 3 || burst_pushes[0] != 4 || burst_pushes[1] != 4 || burst_pushes[2] != 4)
      $display("FAIL ring_pushes_per_burst: got %0d/%0d/%0d required 4/4/4", burst_pushes[0], burst_pushes[1], burst_pushes[2]);
    else passed++;
  endtask

  task automatic test_backpressure();
    bit stall_ok;
    bit ok;
    apply_reset();
    start_stream();
    wait_push(2);
    bus.wr_buffer_full = 1'b1;
    stall_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.s_ready !== 1'b0 || bus.wr_write_buffer !== 1'b0) stall_ok = 1'b0;
      step();
    end
    checks++;
    if (!stall_ok || push_data.size() != 2)
      $display("FAIL full_stall: stall_ok=%0d pushes=%0d required 1 and 2", stall_ok, push_data.size());
    else passed++;
    bus.wr_buffer_full = 1'b0;
    wait_go(2);
    ok = (push_data.size() == 4);
    for (int i = 0; i < 4; i++) if (push_data[i] !== 16'(i)) ok = 1'b0;
    checks++;
    if (!ok) $display("FAIL full_resume_data: %0d pushes, third %h, required 0,1,2,3", push_data.size(), push_data[2]);
    else passed++;
    checks++;
    if (burst_pushes[0] != 4) $display("FAIL full_burst_pushes: got %0d required 4", burst_pushes[0]);
    else passed++;
  endtask

  task automatic test_enable_stop();
    apply_reset();
    start_stream();
    wait_go(1);
    enable = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!busy) break;
    end
    checks++;
    if (busy !== 1'b0 || push_data.size() != 4)
      $display("FAIL stop_at_boundary: busy=%b pushes=%0d required 0 and 4", busy, push_data.size());
    else passed++;
    checks++;
    if (bus.wr_write_base !== 32'd8) $display("FAIL stop_base: got %h required 8", bus.wr_write_base);
    else passed++;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (go_bases.size() != 1) $display("FAIL stop_no_go: got %0d go pulses required 1", go_bases.size());
    else passed++;
    enable = 1'b1;
    wait_go(2);
    checks++;
    if (go_bases[1] !== 32'd8) $display("FAIL reenable_base: got %h required 8", go_bases[1]);
    else passed++;
  endtask

  task automatic test_done_stall();
    bit stall_ok;
    apply_reset();
    bus.wr_done = 1'b0;
    start_stream();
    wait_push(4);
    stall_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.s_ready !== 1'b0 || busy !== 1'b1 || bus.wr_write_base !== 32'd0 || bus.wr_go !== 1'b0) stall_ok = 1'b0;
      step();
    end
    checks++;
    if (!stall_ok || go_bases.size() != 1 || push_data.size() != 4)
      $display("FAIL done_stall: ok=%0d go=%0d pushes=%0d required 1,1,4", stall_ok, go_bases.size(), push_data.size());
    else passed++;
    bus.wr_done = 1'b1;
    step();
    checks++;
    if (bus.wr_go !== 1'b0 || busy !== 1'b1 || bus.s_ready !== 1'b0)
      $display("FAIL advance_cycle: go=%b busy=%b ready=%b required 0 1 0", bus.wr_go, busy, bus.s_ready);
    else passed++;
    step();
    checks++;
    if (bus.wr_go !== 1'b1 || bus.wr_write_base !== 32'd8)
      $display("FAIL go_after_advance: go=%b base=%h required 1 and 8", bus.wr_go, bus.wr_write_base);
    else passed++;
  endtask

  task automatic test_reset_mid_fill();
    apply_reset();
    start_stream();
    wait_push(6);
    checks++;
    if (bus.wr_write_base !== 32'd8 || bus.s_ready !== 1'b1)
      $display("FAIL mid_fill_pre: base=%h ready=%b required 8 and 1", bus.wr_write_base, bus.s_ready);
    else passed++;
    reset = 1'b1;
    step();
    #1;
    checks++;
    if ({busy, bus.wr_go, bus.s_ready, bus.wr_write_buffer} !== 4'b0 || bus.wr_write_base !== 32'd0 || wrap_count !== 16'd0)
      $display("FAIL mid_fill_reset: ctrl=%b base=%h wrap=%h required 0000 0 0",
               {busy, bus.wr_go, bus.s_ready, bus.wr_write_buffer}, bus.wr_write_base, wrap_count);
    else passed++;
    reset = 1'b0;
    clear_log();
    wait_go(1);
    checks++;
    if (go_bases[0] !== 32'd0) $display("FAIL restart_base: got %h required 0", go_bases[0]);
    else passed++;
  endtask

  task automatic test_wrap_saturate();
    apply_reset();
    start_stream();
    wait_go(1);
    force dut.wrap_q = 16'hFFFF;
    #1;
    release dut.wrap_q;
    wait_go(2);
    checks++;
    if (wrap_count !== 16'hFFFF || go_bases[1] !== 32'd8)
      $display("FAIL preset_wrap: wrap=%h base=%h required ffff and 8", wrap_count, go_bases[1]);
    else passed++;
    wait_go(3);
    checks++;
    if (wrap_count !== 16'hFFFF) $display("FAIL wrap_saturate: got %h required ffff", wrap_count);
    else passed++;
    checks++;
    if (go_bases[2] !== 32'd0) $display("FAIL saturate_base: got %h required 0", go_bases[2]);
    else passed++;
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    bus.s_data = 16'd0;
    bus.s_valid = 1'b0;
    bus.wr_done = 1'b1;
    bus.wr_buffer_full = 1'b0;
    pushes_since_go = 0;
    seen_go = 1'b0;
    pushed = 1'b0;
    test_reset();
    test_ring_fill();
    test_backpressure();
    test_enable_stop();
    test_done_stall();
    test_reset_mid_fill();
    test_wrap_saturate();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
